// File: rtl/module_display_ctrl.sv
// Four-digit seven-segment display controller.
// Binary-to-BCD conversion by double-dabble, digit bank, and free-running scan.
module module_display_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bin_valid,
  input  logic [13:0] bin_data,
  output logic        bin_ready,
  output logic        busy,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  transis
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  localparam int unsigned PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PTC = PW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  state_t        state;
  logic [13:0]   shreg;
  logic [15:0]   acc;
  logic [3:0]    step;
  logic          ovf_pend;
  logic [15:0]   digits;
  logic [PW-1:0] pre;
  logic [1:0]    sel;

  logic [14:0]   acc_adj;
  logic [3:0]    cur;
  logic [3:1]    lz;
  logic          blank;

  function automatic logic [3:0] adj3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] enc(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction ahead of each shift; the top
  // bit of the thousands nibble is shifted out anyway.
  assign acc_adj[3:0]   = adj3(acc[3:0]);
  assign acc_adj[7:4]   = adj3(acc[7:4]);
  assign acc_adj[11:8]  = adj3(acc[11:8]);
  assign acc_adj[14:12] = 3'(adj3(acc[15:12]));

  // Conversion FSM with registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      step      <= '0;
      ovf_pend  <= 1'b0;
      digits    <= '0;
      ovf       <= 1'b0;
      bin_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bin_valid && bin_ready) begin
            shreg     <= bin_data;
            acc       <= '0;
            step      <= '0;
            ovf_pend  <= (bin_data > 14'd9999);
            state     <= CONV;
            bin_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CONV: begin
          acc   <= {acc_adj, shreg[13]};
          shreg <= {shreg[12:0], 1'b0};
          step  <= step + 4'd1;
          if (step == 4'd13) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          digits    <= acc;
          ovf       <= ovf_pend;
          state     <= IDLE;
          bin_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bin_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Free-running prescaler and digit selector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      sel <= '0;
    end else if (pre == PTC) begin
      pre <= '0;
      sel <= sel + 2'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Pick the digit under scan and decide blanking.
  always_comb begin
    cur   = digits[3:0];
    blank = 1'b0;
    lz[3] = (digits[15:12] == 4'd0);
    lz[2] = lz[3] && (digits[11:8] == 4'd0);
    lz[1] = lz[2] && (digits[7:4] == 4'd0);
    case (sel)
      2'd0: begin
        cur   = digits[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        cur   = digits[7:4];
        blank = lz[1];
      end
      2'd2: begin
        cur   = digits[11:8];
        blank = lz[2];
      end
      default: begin
        cur   = digits[15:12];
        blank = lz[3];
      end
    endcase
    blank = blank && BLANK_LZ && !ovf;
  end

  // Segment mux: dashes on overflow, then blanking.
  always_comb begin
    seg = enc(cur);
    unique case (1'b1)
      ovf:     seg = SEG_DASH;
      blank:   seg = SEG_BLANK;
      default: seg = enc(cur);
    endcase
  end

  assign transis = 4'b0001 << sel;

endmodule

// File: tb/tb_module_display_ctrl.sv
// Directed bench for module_display_ctrl.
// Two instances share stimulus: blanking on and off.
module tb_module_display_ctrl;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        bin_valid = 1'b0;
  logic [13:0] bin_data = '0;
  logic        bin_ready0, busy0, ovf0;
  logic        bin_ready1, busy1, ovf1;
  logic [6:0]  seg0, seg1;
  logic [3:0]  transis0, transis1;

  int checks = 0;
  int errors = 0;
  int tcyc;

  module_display_ctrl #(
    .SCAN_DIV(4),
    .BLANK_LZ(1'b1)
  ) u0 (
    .clk(clk),
    .rst_n(rst_n),
    .bin_valid(bin_valid),
    .bin_data(bin_data),
    .bin_ready(bin_ready0),
    .busy(busy0),
    .ovf(ovf0),
    .seg(seg0),
    .transis(transis0)
  );

  module_display_ctrl #(
    .SCAN_DIV(4),
    .BLANK_LZ(1'b0)
  ) u1 (
    .clk(clk),
    .rst_n(rst_n),
    .bin_valid(bin_valid),
    .bin_data(bin_data),
    .bin_ready(bin_ready1),
    .busy(busy1),
    .ovf(ovf1),
    .seg(seg1),
    .transis(transis1)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; a frame is 16 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcyc <= 0;
    else tcyc <= tcyc + 1;
  end

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [13:0] v);
    @(negedge clk);
    chk("rdy_pre", 32'(bin_ready0), 32'd1);
    bin_valid = 1'b1;
    bin_data  = v;
    @(posedge clk);
    @(negedge clk);
    bin_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bin_data = 14'($urandom);
      chk("busy_win", 32'({busy0, bin_ready0}),
          32'(2'b10));
      @(negedge clk);
    end
    chk("busy_end", 32'({busy0, bin_ready0}),
        32'(2'b01));
  endtask

  task automatic frame(
    input string tag,
    input logic [27:0] ea,
    input logic [27:0] eb
  );
    int d;
    for (int w = 0; w < 20 && (tcyc % 16) != 0; w++)
      @(negedge clk);
    if ((tcyc % 16) != 0) begin
      errors++;
      $error("FAIL %s_align: observed %0d expected 0",
             tag, tcyc % 16);
    end
    for (int k = 0; k < 16; k++) begin
      d = k / 4;
      chk(tag, 32'({transis0, seg0}),
          32'({4'b0001 << d, ea[d*7 +: 7]}));
      chk(tag, 32'({transis1, seg1}),
          32'({4'b0001 << d, eb[d*7 +: 7]}));
      @(negedge clk);
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({transis0, seg0, bin_ready0,
        busy0, ovf0}),
        32'({4'b0001, S0, 1'b1, 1'b0, 1'b0}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    accept(14'd1234);
    chk("ovf_1234", 32'(ovf0), 32'd0);
    frame("f1234", {S1, S2, S3, S4}, {S1, S2, S3, S4});

    // Reset mid-frame with selector on tens
    for (int w = 0; w < 20 && (tcyc % 16) != 6; w++)
      @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'({transis0, seg0, bin_ready0,
        busy0, ovf0}),
        32'({4'b0001, S0, 1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;

    accept(14'd9999);
    chk("ovf_9999", 32'(ovf0), 32'd0);
    frame("f9999", {S9, S9, S9, S9}, {S9, S9, S9, S9});

    accept(14'd10000);
    chk("ovf_10000", 32'(ovf0), 32'd1);
    chk("ovf_10000b", 32'(ovf1), 32'd1);
    frame("f10000", {SD, SD, SD, SD}, {SD, SD, SD, SD});

    accept(14'd16383);
    chk("ovf_16383", 32'(ovf0), 32'd1);
    frame("f16383", {SD, SD, SD, SD}, {SD, SD, SD, SD});

    accept(14'd7);
    chk("ovf_7", 32'(ovf0), 32'd0);
    frame("f7", {SB, SB, SB, S7}, {S0, S0, S0, S7});

    accept(14'd0);
    frame("f0", {SB, SB, SB, S0}, {S0, S0, S0, S0});

    accept(14'd1005);
    frame("f1005", {S1, S0, S0, S5}, {S1, S0, S0, S5});

    // Reset pulse across T5 of a 5678 conversion
    @(negedge clk);
    bin_valid = 1'b1;
    bin_data  = 14'd5678;
    @(posedge clk);
    @(negedge clk);
    bin_valid = 1'b0;
    chk("mc_busy", 32'(busy0), 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mc_rst", 32'({bin_ready0, busy0, ovf0}),
        32'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mc_idle", 32'({bin_ready0, busy0, ovf0}),
        32'(3'b100));
    frame("fmc", {SB, SB, SB, S0}, {S0, S0, S0, S0});

    accept(14'd42);
    frame("f42", {SB, SB, S4, S2}, {S0, S0, S4, S2});

    // Valid held high; data changes every cycle
    for (int n = 0; n <= 48; n++) begin
      chk("hs_rdy", 32'(bin_ready0),
          32'((n % 16) == 0));
      bin_data  = 14'(1000 + 37 * n);
      bin_valid = (n < 40);
      @(negedge clk);
    end
    bin_valid = 1'b0;
    chk("hs_ovf", 32'(ovf0), 32'd0);
    frame("fhs", {S2, S1, S8, S4}, {S2, S1, S8, S4});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
